// File: rtl/decode_stage_hs.sv
// ID/EX register with internal register file, writeback bypass and load-use bubble insertion.
// Latency: 1 cycle from acceptance to out_valid. Backpressure: E holds while out_valid & ~out_ready, in_ready drops.
module decode_stage_hs #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int CTRL_W      = 12,
    parameter int STALL_CNT_W = 16,
    parameter bit BYPASS_WB   = 1'b1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr_d,
    input  logic [XLEN-1:0]        pc_d,
    input  logic [XLEN-1:0]        pcplus4_d,
    input  logic [CTRL_W-1:0]      ctrl_d,
    input  logic [XLEN-1:0]        imm_d,
    input  logic                   mem_read_d,
    input  logic                   flush,
    input  logic                   reg_write_w,
    input  logic [AW-1:0]          rd_w,
    input  logic [XLEN-1:0]        result_w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      ctrl_e,
    output logic                   mem_read_e,
    output logic [XLEN-1:0]        rd1_e,
    output logic [XLEN-1:0]        rd2_e,
    output logic [XLEN-1:0]        imm_e,
    output logic [XLEN-1:0]        pc_e,
    output logic [XLEN-1:0]        pcplus4_e,
    output logic [AW-1:0]          rd_e,
    output logic [AW-1:0]          rs1_e,
    output logic [AW-1:0]          rs2_e,
    input  logic                   stall_cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0]        rf_q [NREGS];
    logic                   out_valid_q, mem_read_q;
    logic [CTRL_W-1:0]      ctrl_q;
    logic [XLEN-1:0]        rd1_q, rd2_q, imm_q, pc_q, pcplus4_q;
    logic [AW-1:0]          rd_q, rs1_q, rs2_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [AW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rd1_val, rd2_val;
    logic            wb_hit, hazard, slot_free, take;
    logic            unused_instr;

    assign rs1_idx      = instr_d[15 +: AW];
    assign rs2_idx      = instr_d[20 +: AW];
    assign rd_idx       = instr_d[7 +: AW];
    assign unused_instr = ^instr_d;

    // Same-cycle writeback wins over the stored value when forwarding is enabled.
    assign wb_hit  = BYPASS_WB && reg_write_w && (rd_w != '0);
    assign rd1_val = (rs1_idx == '0) ? '0 :
                     (wb_hit && rd_w == rs1_idx) ? result_w : rf_q[rs1_idx];
    assign rd2_val = (rs2_idx == '0) ? '0 :
                     (wb_hit && rd_w == rs2_idx) ? result_w : rf_q[rs2_idx];

    assign hazard    = out_valid_q && mem_read_q && (rd_q != '0) && in_valid &&
                       ((rd_q == rs1_idx) || (rd_q == rs2_idx));
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = flush || (slot_free && !hazard);
    assign take      = !flush && slot_free && in_valid && !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (reg_write_w && rd_w != '0) begin
            rf_q[rd_w] <= result_w;
        end
    end

    // Flush and bubble both clear valid/ctrl/load flag; data fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            pcplus4_q   <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            mem_read_q  <= mem_read_d;
            ctrl_q      <= ctrl_d;
            rd1_q       <= rd1_val;
            rd2_q       <= rd2_val;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            pcplus4_q   <= pcplus4_d;
            rd_q        <= rd_idx;
            rs1_q       <= rs1_idx;
            rs2_q       <= rs2_idx;
        end else if (flush || slot_free) begin
            out_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (in_valid && !in_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign out_valid  = out_valid_q;
    assign mem_read_e = mem_read_q;
    assign ctrl_e     = ctrl_q;
    assign rd1_e      = rd1_q;
    assign rd2_e      = rd2_q;
    assign imm_e      = imm_q;
    assign pc_e       = pc_q;
    assign pcplus4_e  = pcplus4_q;
    assign rd_e       = rd_q;
    assign rs1_e      = rs1_q;
    assign rs2_e      = rs2_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised decode stage: ID/EX pipeline register with an internal register file and valid/ready handshakes on both sides.
- Adds behaviour the fixed-width stall/flush decode stage does not have: writeback-to-read bypass, internal load-use hazard detection with bubble insertion, backpressure from execute, and a saturating stall counter.
- Control bits and immediate come from the external control unit and sign extender as an opaque bundle; this block does not decode them.

Parameters:
- XLEN, 32, datapath width of registers, PC and immediate.
- NREGS, 32, register file depth; AW = clog2(NREGS) is the register-index width.
- CTRL_W, 12, width of the opaque control bundle.
- STALL_CNT_W, 16, stall counter width.
- BYPASS_WB, 1, 1 = a same-cycle writeback is forwarded to the decode read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- instr_d  in  32  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], low AW bits used.
- pc_d  in  XLEN  instruction PC.
- pcplus4_d  in  XLEN  PC+4.
- ctrl_d  in  CTRL_W  control bundle from the control unit.
- imm_d  in  XLEN  extended immediate.
- mem_read_d  in  1  instruction is a load.
- flush  in  1  kill the decode slot and the E slot.
- reg_write_w  in  1  writeback enable.
- rd_w  in  AW  writeback destination.
- result_w  in  XLEN  writeback data.
- out_valid  out  1  E register holds a valid instruction.
- out_ready  in  1  execute consumes the E register.
- ctrl_e  out  CTRL_W  registered control bundle.
- mem_read_e  out  1  registered load flag.
- rd1_e, rd2_e  out  XLEN  registered operands.
- imm_e, pc_e, pcplus4_e  out  XLEN  registered immediate, PC, PC+4.
- rd_e, rs1_e, rs2_e  out  AW  registered register indices.
- stall_cnt_clr  in  1  synchronous clear of the stall counter.
- stall_cnt  out  STALL_CNT_W  stall-cycle count.

Behaviour:
- Reset (async, rst=1): every output register, stall_cnt and all register-file entries go to 0; out_valid=0. A reset asserted mid-transfer drops the in-flight instruction.
- Register file:
  - Write at posedge when reg_write_w=1 and rd_w!=0; x0 always reads 0.
  - Reads are combinational.
  - If BYPASS_WB=1, reg_write_w=1, rd_w!=0 and rd_w equals the read index, the read returns result_w in the same cycle.
  - If BYPASS_WB=0, the old value is read.
- Hazard (combinational): hazard = out_valid & mem_read_e & (rd_e!=0) & in_valid & (rd_e==rs1_d | rd_e==rs2_d).
- Slot free: slot_free = ~out_valid | out_ready.
- in_ready = flush | (slot_free & ~hazard).
- Register update, priority order:
  - flush: out_valid<=0, ctrl_e<=0, mem_read_e<=0. Any instruction presented is accepted and discarded. Data fields hold.
  - else slot_free & in_valid & ~hazard: capture all D fields, out_valid<=1. Latency is 1 cycle from acceptance to out_valid.
  - else slot_free: bubble. out_valid<=0, ctrl_e<=0, mem_read_e<=0.
  - else (out_valid=1, out_ready=0): hold every E field unchanged.
- Load-use hazard costs exactly one bubble. Once the load leaves E, hazard deasserts and the dependent instruction is accepted on the next slot_free cycle.
- Handshake rules:
  - in_ready does not depend on in_valid except through hazard.
  - E outputs are stable while out_valid=1 and out_ready=0.
- stall_cnt, priority order:
  - stall_cnt_clr: stall_cnt<=0.
  - else if in_valid & ~in_ready: stall_cnt+1, saturating at 2^STALL_CNT_W-1 (no wrap).
  - flush cycles never count, since in_ready=1.
- Simultaneous events:
  - Writeback to rs1 while the same instruction is captured: rd1_e gets result_w when bypass is enabled.
  - flush and hazard together: flush wins.
  - flush with out_ready=0: the E slot is still killed.

Test Plan:
- Reset: rst=1 mid-stream -> out_valid=0, all E outputs 0, stall_cnt=0; a later read of x5 returns 0.
- Back-to-back ALU ops with out_ready=1: instr at PC 0x10 and 0x14 -> each appears on pc_e one cycle after acceptance, in_ready stays 1.
- Load-use: load with rd=5, mem_read_d=1, then add with rs1=5 -> one bubble cycle, in_ready=0 for 1 cycle, stall_cnt=1, add captured in the following cycle.
- WB bypass: reg_write_w=1, rd_w=3, result_w=0xDEADBEEF in the same cycle as capturing an instr with rs2=3 -> rd2_e=0xDEADBEEF. BYPASS_WB=0 -> old value 0. rd_w=0 -> x0 still reads 0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> E fields frozen, in_ready=0, stall_cnt increments by 3. Release -> next instr captured.
- Flush plus saturation: flush with out_ready=0 -> out_valid=0 next cycle, ctrl_e=0. STALL_CNT_W=2 held stalled 6 cycles -> stall_cnt=3. stall_cnt_clr -> 0.
